// File: rtl/bvb_bank_sched.sv
// rtl/bvb_bank_sched.sv - demand-driven bank scheduler for the banked vector RAM
module bvb_bank_sched #(
  parameter int CH         = 4,
  parameter int SPLIT_BITS = 3,
  parameter int NUM_BANKS  = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        img_base_i,
  input  logic                     flush_i,
  input  logic [CH-1:0]            req_valid_i,
  input  logic [CH*SPLIT_BITS-1:0] req_bank_i,
  input  logic [CH-1:0]            wr_ok_i,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [SPLIT_BITS-1:0]    bank_o,
  output logic                     bank_vld_o,
  output logic [CH-1:0]            grant_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_bank_o
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [SPLIT_BITS-1:0]   last_q, last_d;
  logic [SPLIT_BITS-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    bank_vld_q, bank_vld_d;
  logic [CH-1:0]           grant_q, grant_d;
  logic                    err_q, err_d;
  logic                    done;

  logic [CH-1:0]           elig;
  logic [CH-1:0]           hit;
  logic [NUM_BANKS-1:0]    pend;
  logic                    bad;
  logic                    found;
  logic [SPLIT_BITS-1:0]   sel;
  logic                    active;

  assign active = (state_q != S_IDLE);

  // Per-channel eligibility, pending-bank mask, illegal-bank detect and bank-hit for grants
  always_comb begin
    elig = '0;
    hit  = '0;
    pend = '0;
    bad  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (req_valid_i[i] && int'(req_bank_i[i*SPLIT_BITS +: SPLIT_BITS]) >= NUM_BANKS) begin
        bad = 1'b1;
      end
      // A head whose pop is already in flight (grant high) must not be served again.
      elig[i] = req_valid_i[i] & wr_ok_i[i] & ~grant_q[i] &
                (int'(req_bank_i[i*SPLIT_BITS +: SPLIT_BITS]) < NUM_BANKS);
      hit[i]  = elig[i] & (req_bank_i[i*SPLIT_BITS +: SPLIT_BITS] == bank_q);
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (elig[i] && req_bank_i[i*SPLIT_BITS +: SPLIT_BITS] == SPLIT_BITS'(k)) begin
          pend[k] = 1'b1;
        end
      end
    end
  end

  // Round-robin search for the first pending bank after the last one served
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = 1; off <= NUM_BANKS; off++) begin
      int idx;
      idx = (int'(last_q) + off) % NUM_BANKS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = SPLIT_BITS'(idx);
      end
    end
  end

  // Image sequencing: next state, base capture and completion pulse
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SWEEP;
          base_d  = img_base_i;
        end
      end
      S_SWEEP: begin
        if (flush_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (req_valid_i == '0 && grant_q == '0 && !bank_vld_q) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read issue, grant alignment with the RAM latency, and sticky bank error
  always_comb begin
    bank_vld_d = active & found;
    bank_d     = bank_q;
    addr_d     = addr_q;
    last_d     = last_q;
    if (active && found) begin
      bank_d = sel;
      addr_d = base_q + ADDR_W'(sel);
      last_d = sel;
    end
    grant_d = bank_vld_q ? hit : '0;
    err_d   = err_q | bad;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset drops any pending grant and aborts the image silently
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      base_q     <= '0;
      last_q     <= SPLIT_BITS'(NUM_BANKS - 1);
      bank_q     <= '0;
      addr_q     <= '0;
      bank_vld_q <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      base_q     <= base_d;
      last_q     <= last_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      bank_vld_q <= bank_vld_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

  assign ram_addr_o = addr_q;
  assign bank_o     = bank_q;
  assign bank_vld_o = bank_vld_q;
  assign grant_o    = grant_q;
  assign busy_o     = active;
  assign done_o     = done;
  assign err_bank_o = err_q;

endmodule

// File: tb/tb_bvb_bank_sched.sv
// tb/tb_bvb_bank_sched.sv - self-checking bench for bvb_bank_sched
module tb_bvb_bank_sched;
  localparam int CH = 4;
  localparam int SB = 3;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [AW-1:0]   img_base;
  logic [CH-1:0]   req_valid;
  logic [CH*SB-1:0] req_bank;
  logic [CH-1:0]   wr_ok;

  logic [AW-1:0]   ram_addr8, ram_addr6;
  logic [SB-1:0]   bank8, bank6;
  logic            bank_vld8, bank_vld6;
  logic [CH-1:0]   grant8, grant6;
  logic            busy8, busy6, done8, done6, err8, err6;

  bvb_bank_sched #(.CH(CH), .SPLIT_BITS(SB), .NUM_BANKS(8), .ADDR_W(AW)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .img_base_i(img_base), .flush_i(flush),
    .req_valid_i(req_valid), .req_bank_i(req_bank), .wr_ok_i(wr_ok),
    .ram_addr_o(ram_addr8), .bank_o(bank8), .bank_vld_o(bank_vld8), .grant_o(grant8),
    .busy_o(busy8), .done_o(done8), .err_bank_o(err8)
  );

  bvb_bank_sched #(.CH(CH), .SPLIT_BITS(SB), .NUM_BANKS(6), .ADDR_W(AW)) u_dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .img_base_i(img_base), .flush_i(flush),
    .req_valid_i(req_valid), .req_bank_i(req_bank), .wr_ok_i(wr_ok),
    .ram_addr_o(ram_addr6), .bank_o(bank6), .bank_vld_o(bank_vld6), .grant_o(grant6),
    .busy_o(busy6), .done_o(done6), .err_bank_o(err6)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    g;
    logic [AW-1:0] a;
  } exp_t;

  typedef struct {
    logic [AW-1:0] base;
    int            ch;
    logic [SB-1:0] b;
    logic [AW-1:0] addr;
    logic [3:0]    g;
  } vec_t;

  logic [SB-1:0] fq [CH][$];
  exp_t          sb[$];
  exp_t          e;
  vec_t          vt[5];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_grant_cyc = 0;
  logic [CH-1:0] grant_s = '0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_vld = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Channel id FIFOs: a granted head is popped at the end of its grant cycle
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < CH; i++) begin
      if (grant_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    for (int i = 0; i < CH; i++) begin
      req_valid[i] = (fq[i].size() > 0);
      req_bank[i*SB +: SB] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  end

  // Scoreboard: every grant must match the next expected {mask, read address}
  always @(negedge clk) begin
    grant_s = grant8;
    if (grant8 != '0) begin
      last_grant_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got %b expected none", grant8);
      end else begin
        e = sb.pop_front();
        check("grant_mask", 32'(grant8), 32'(e.g));
        check("grant_addr", 32'(prev_addr), 32'(e.a));
        check("grant_after_vld", 32'(prev_vld), 32'd1);
      end
    end
    if (done8) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_addr = ram_addr8;
    prev_vld  = bank_vld8;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit quiet();
    if (sb.size() != 0) return 1'b0;
    for (int i = 0; i < CH; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(string name);
    int n = 0;
    while (!quiet() && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(quiet()), 32'd1);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy8 && n < 60);
    check(name, 32'(busy8), 32'd0);
  endtask

  initial begin
    int k6_grant;

    vt[0] = '{10'h040, 0, 3'd5, 10'h045, 4'b0001};
    vt[1] = '{10'h100, 1, 3'd0, 10'h100, 4'b0010};
    vt[2] = '{10'h3FE, 3, 3'd4, 10'h002, 4'b1000};
    vt[3] = '{10'h3F9, 2, 3'd7, 10'h000, 4'b0100};
    vt[4] = '{10'h2A0, 3, 3'd6, 10'h2A6, 4'b1000};

    rst = 1'b0; start = 1'b0; flush = 1'b0; img_base = '0;
    req_valid = '0; req_bank = '0; wr_ok = 4'b1111;

    // Reset and idle behaviour
    repeat (3) tick();
    @(negedge clk);
    check("rst_addr", 32'(ram_addr8), 32'd0);
    check("rst_bank", 32'(bank8), 32'd0);
    check("rst_vld", 32'(bank_vld8), 32'd0);
    check("rst_grant", 32'(grant8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_err", 32'(err8), 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("idle_busy", 32'(busy8), 32'd0);
    check("idle_vld", 32'(bank_vld8), 32'd0);
    tick();
    for (int i = 0; i < CH; i++) fq[i].push_back(3'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_req_quiet", 32'({bank_vld8, grant8}), 32'd0);
    end
    tick();
    for (int i = 0; i < CH; i++) fq[i].delete();
    repeat (2) tick();

    // Table: one image per record; flush while the request is still queued
    for (int k = 0; k < 5; k++) begin
      tick();
      start = 1'b1;
      img_base = vt[k].base;
      fq[vt[k].ch].push_back(vt[k].b);
      sb.push_back('{vt[k].g, vt[k].addr});
      done_cnt = 0;
      tick();
      start = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_idle("vec_busy_falls");
      check("vec_done_once", 32'(done_cnt), 32'd1);
      check("vec_done_timing", 32'(done_cyc), 32'(last_grant_cyc + 1));
      check("vec_sb_empty", 32'(sb.size()), 32'd0);
    end

    // Round-robin with a shared bank, starting from last = 2
    tick();
    start = 1'b1;
    img_base = 10'h000;
    fq[0].push_back(3'd2);
    sb.push_back('{4'b0001, 10'h002});
    tick();
    start = 1'b0;
    wait_quiet("rr_setup");
    repeat (3) tick();
    fq[0].push_back(3'd3);
    fq[1].push_back(3'd1);
    fq[2].push_back(3'd3);
    sb.push_back('{4'b0101, 10'h003});
    sb.push_back('{4'b0010, 10'h001});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bank_vld8) check("rr_no_wasted_bank", 32'(bank8 == 3'd1 || bank8 == 3'd3), 32'd1);
    end
    wait_quiet("rr_done");

    // Back-pressure: a full output FIFO keeps its bank unread
    tick();
    wr_ok = 4'b1101;
    fq[1].push_back(3'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_no_read", 32'(bank_vld8 && bank8 == 3'd2), 32'd0);
    end
    tick();
    wr_ok = 4'b1111;
    sb.push_back('{4'b0010, 10'h002});
    wait_quiet("bp_served");
    tick();
    done_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("bp_busy_falls");
    check("bp_done_once", 32'(done_cnt), 32'd1);

    // Illegal bank on the 6-bank instance, then reset mid-sweep
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("err6_clear", 32'(err6), 32'd0);
    tick();
    start = 1'b1;
    img_base = 10'h000;
    fq[2].push_back(3'd7);
    sb.push_back('{4'b0100, 10'h007});
    tick();
    start = 1'b0;
    k6_grant = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant6[2]) k6_grant++;
    end
    check("err6_set", 32'(err6), 32'd1);
    check("err6_no_grant", 32'(k6_grant), 32'd0);
    check("err8_legal", 32'(err8), 32'd0);
    wait_quiet("err_dut8_served");
    check("mid_busy", 32'({busy8, busy6}), 32'b11);
    tick();
    done_cnt = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_busy6", 32'(busy6), 32'd0);
    check("abort_err6", 32'(err6), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
